vga_timing_gen: RTL and testbench

Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock produced by the clock wizard, and consumes its `locked` status. Counters run only while the MMCM is locked. The block drives hsync/vsync, data-enable and pixel coordinates to the sprite/render pipeline and the VGA pins. It is the first logic stage in the pixel-clock domain.

---
 rtl/vga_timing_pkg.sv | 81 ++++++++
 rtl/sync_2ff.sv | 43 ++++
 rtl/vga_timing_gen.sv | 227 ++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Purpose:
//   Shared definitions for the pixel-clock raster timing block. Holds the
//   default 640x480@60 Hz timing constants, the derived line and frame
//   totals, the coordinate width, the two-state controller encoding and a
//   couple of small helpers used by the counter and decode logic.
//
// Contents:
//   COORD_W          width of the pixel_x / pixel_y coordinates
//   DEF_H_* / DEF_V_* default horizontal / vertical timing, in pixels / lines
//   DEF_SYNC_ACTIVE  asserted level of hsync / vsync (0 = active-low)
//   DEF_H_TOTAL      pixels per line including blanking
//   DEF_V_TOTAL      lines per frame including blanking
//   MAX_TOTAL        largest line or frame total the counters can represent
//   vga_state_t      IDLE / RUN controller state
//   wrapInc()        increment with wrap back to zero after a given last value
//   syncLevel()      sync output level for a counter inside / outside a window
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Coordinates are 10 bits wide, enough for both 800 pixels and 525 lines.
  localparam int COORD_W = 10;

  // Default horizontal timing, in pixel clocks.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Standard VGA uses negative sync pulses for this mode.
  localparam logic DEF_SYNC_ACTIVE = 1'b0;

  // Derived totals: 800 pixels per line and 525 lines per frame.
  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // A COORD_W-bit counter can cover at most this many positions.
  localparam int MAX_TOTAL = 1 << COORD_W;

  // The controller only ever waits for lock or scans the raster.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_t;

  // Next value of a counter that runs 0..last and then starts over at 0.
  function automatic logic [COORD_W-1:0] wrapInc(
    input logic [COORD_W-1:0] cnt,
    input logic [COORD_W-1:0] last
  );
    if (cnt == last) begin
      wrapInc = '0;
    end else begin
      wrapInc = cnt + 1'b1;
    end
  endfunction

  // Sync level for a counter value: the active level while first <= cnt <= last,
  // the opposite level everywhere else on the line or frame.
  function automatic logic syncLevel(
    input logic [COORD_W-1:0] cnt,
    input logic [COORD_W-1:0] first,
    input logic [COORD_W-1:0] last,
    input logic               activeLevel
  );
    if ((cnt >= first) && (cnt <= last)) begin
      syncLevel = activeLevel;
    end else begin
      syncLevel = ~activeLevel;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Purpose:
//   Two-flop synchronizer for a single level-type status bit arriving from
//   another clock domain (or from an unclocked source such as an MMCM lock
//   output). The first flop may go metastable; the second gives it a full
//   clock period to settle before anything downstream looks at it. Only
//   slow-moving levels belong here: pulses shorter than a clock period can
//   be lost, and multi-bit values must not be passed through parallel copies.
//
// Ports:
//   i_clk     destination clock
//   i_resetN  asynchronous, active-low reset; both flops clear to 0
//   i_d       asynchronous input level
//   o_q       synchronized level, two destination clock edges late
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic i_clk,
  input  logic i_resetN,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw input through two flops. Clearing to 0 means that
  // anything downstream sees the input as deasserted until it has been
  // sampled cleanly after reset.
  always_ff @(posedge i_clk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose:
//   Raster timing generator for the pixel-clock domain. It waits for the
//   clock wizard to report lock, then scans a line counter and a frame
//   counter over the full raster (active area plus porches and sync) and
//   decodes them into sync, data-enable, coordinates and start-of-line /
//   start-of-frame pulses. Losing lock drops the block back to idle with
//   every output at its reset value; the next lock always starts again at
//   the top-left pixel.
//
// Parameters:
//   H_ACTIVE, H_FP, H_SYNC, H_BP   horizontal timing in pixel clocks
//   V_ACTIVE, V_FP, V_SYNC, V_BP   vertical timing in lines
//   SYNC_ACTIVE                    asserted level of hsync / vsync
//
// Ports:
//   clk_in1      pixel clock from the clock wizard; the only clock here
//   reset_n      asynchronous, active-low reset
//   locked       MMCM lock status, asynchronous to clk_in1
//   hsync        horizontal sync
//   vsync        vertical sync, changes on the same cycle as pixel_x = 0
//   de           high while the coordinates are inside the visible area
//   pixel_x      horizontal position, also valid during blanking
//   pixel_y      vertical position, also valid during blanking
//   frame_start  one-cycle pulse at (0,0)
//   line_start   one-cycle pulse at pixel_x = 0 on every line
//   running      high while the controller is scanning
//
// Latency:
//   locked is sampled at edge E0, seen synchronized after E1, the counters
//   start at (0,0) after E2, and the first pixel appears on the outputs
//   after E3. A loss of lock follows the same three-edge path back to idle.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic               clk_in1,
  input  logic               reset_n,
  input  logic               locked,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start,
  output logic               line_start,
  output logic               running
);

  // Full line and frame lengths for this parameter set.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width versions of the boundaries used by the counters and the
  // decode, so every comparison below is between equal-width vectors.
  localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT_END   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_END   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_FIRST    = COORD_W'(H_ACTIVE + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST     = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST    = COORD_W'(V_ACTIVE + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST     = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // The counters are COORD_W bits wide, so a timing set whose line or frame
  // is longer than the counter range would silently alias. Refuse to
  // elaborate such a configuration rather than generate a broken raster.
  if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_totalTooBig
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds the coordinate counter range");
  end

  // Synchronized lock status.
  logic w_lockS;

  // Controller state and raster counters.
  vga_state_t         r_state;
  vga_state_t         w_stateNext;
  logic [COORD_W-1:0] r_hCnt;
  logic [COORD_W-1:0] r_vCnt;
  logic [COORD_W-1:0] w_hNext;
  logic [COORD_W-1:0] w_vNext;

  // Decoded values of the current counters, registered one cycle later.
  logic w_deNext;
  logic w_hsyncNext;
  logic w_vsyncNext;
  logic w_lineStartNext;
  logic w_frameStartNext;

  // Output registers.
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [COORD_W-1:0] r_pixelX;
  logic [COORD_W-1:0] r_pixelY;
  logic               r_frameStart;
  logic               r_lineStart;
  logic               r_running;

  // The MMCM lock output is not related to clk_in1 edges, so it is brought
  // into the pixel domain before the controller acts on it.
  sync_2ff u_lockSync (
    .i_clk    (clk_in1),
    .i_resetN (reset_n),
    .i_d      (locked),
    .o_q      (w_lockS)
  );

  // State and counter registers. All decisions are made in the next-state
  // logic below; this block only captures them.
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_hCnt  <= '0;
      r_vCnt  <= '0;
    end else begin
      r_state <= w_stateNext;
      r_hCnt  <= w_hNext;
      r_vCnt  <= w_vNext;
    end
  end

  // Next-state and counter logic. Entering RUN and leaving RUN both force
  // the counters to zero, so a relock always starts a fresh frame at (0,0)
  // instead of resuming where the scan stopped. While running, the line
  // counter steps every cycle and the frame counter steps only on the cycle
  // where the line counter wraps.
  always_comb begin
    w_stateNext = r_state;
    w_hNext     = r_hCnt;
    w_vNext     = r_vCnt;
    case (r_state)
      IDLE: begin
        if (w_lockS) begin
          w_stateNext = RUN;
          w_hNext     = '0;
          w_vNext     = '0;
        end
      end
      RUN: begin
        if (!w_lockS) begin
          w_stateNext = IDLE;
          w_hNext     = '0;
          w_vNext     = '0;
        end else begin
          w_hNext = wrapInc(r_hCnt, H_LAST);
          if (r_hCnt == H_LAST) begin
            w_vNext = wrapInc(r_vCnt, V_LAST);
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_hNext     = '0;
        w_vNext     = '0;
      end
    endcase
  end

  // Raster decode of the present counter values. Because vsync is decoded
  // from the frame counter, which only moves when the line counter wraps,
  // its edges land on the same output cycle as pixel_x = 0.
  always_comb begin
    w_deNext         = (r_hCnt < H_ACT_END) && (r_vCnt < V_ACT_END);
    w_hsyncNext      = syncLevel(r_hCnt, HS_FIRST, HS_LAST, SYNC_ACTIVE);
    w_vsyncNext      = syncLevel(r_vCnt, VS_FIRST, VS_LAST, SYNC_ACTIVE);
    w_lineStartNext  = (r_hCnt == '0);
    w_frameStartNext = (r_hCnt == '0) && (r_vCnt == '0);
  end

  // Output registers. While scanning they carry the decode of the counters
  // from the previous cycle; in IDLE they are held at exactly the values
  // they take in reset, so downstream logic sees an idle, blanked screen
  // with syncs deasserted whenever the clock is not trustworthy.
  always_ff @(posedge clk_in1 or negedge reset_n) begin
    if (!reset_n) begin
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_de         <= 1'b0;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_running    <= 1'b0;
    end else if (r_state == RUN) begin
      r_hsync      <= w_hsyncNext;
      r_vsync      <= w_vsyncNext;
      r_de         <= w_deNext;
      r_pixelX     <= r_hCnt;
      r_pixelY     <= r_vCnt;
      r_frameStart <= w_frameStartNext;
      r_lineStart  <= w_lineStartNext;
      r_running    <= 1'b1;
    end else begin
      r_hsync      <= ~SYNC_ACTIVE;
      r_vsync      <= ~SYNC_ACTIVE;
      r_de         <= 1'b0;
      r_pixelX     <= '0;
      r_pixelY     <= '0;
      r_frameStart <= 1'b0;
      r_lineStart  <= 1'b0;
      r_running    <= 1'b0;
    end
  end

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign pixel_x     = r_pixelX;
  assign pixel_y     = r_pixelY;
  assign frame_start = r_frameStart;
  assign line_start  = r_lineStart;
  assign running     = r_running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Drives two copies of the timing generator from the same clock, reset and
// lock input: one with the standard 640x480 timing, and one with a tiny
// raster (35x17, active-high sync) so whole frames fit in a short run.
// A lock-history model predicts every output on every cycle; a few
// directed measurements with hand-computed numbers pin the model down.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  // Small raster: line = 20+4+6+5 = 35, frame = 8+3+2+4 = 17 lines = 595 cycles.
  localparam int   S_HA   = 20;
  localparam int   S_HF   = 4;
  localparam int   S_HS   = 6;
  localparam int   S_HB   = 5;
  localparam int   S_VA   = 8;
  localparam int   S_VF   = 3;
  localparam int   S_VS   = 2;
  localparam int   S_VB   = 4;
  localparam logic S_SYNC = 1'b1;

  logic clk      = 1'b0;
  logic resetN   = 1'b1;
  logic lockedIn = 1'b0;

  logic               fHsync, fVsync, fDe, fFs, fLs, fRun;
  logic [COORD_W-1:0] fX, fY;
  logic               sHsync, sVsync, sDe, sFs, sLs, sRun;
  logic [COORD_W-1:0] sX, sY;

  int assertions = 0;
  int failures   = 0;
  bit checkEn    = 1'b0;

  // lockHist[k] is the lock level the design saw k edges ago (0 while in
  // reset); runHist[k] is how many consecutive locked samples ended there.
  bit lockHist[4];
  int runHist[4];

  always #5 clk = ~clk;

  vga_timing_gen dutFull (
    .clk_in1     (clk),
    .reset_n     (resetN),
    .locked      (lockedIn),
    .hsync       (fHsync),
    .vsync       (fVsync),
    .de          (fDe),
    .pixel_x     (fX),
    .pixel_y     (fY),
    .frame_start (fFs),
    .line_start  (fLs),
    .running     (fRun)
  );

  vga_timing_gen #(
    .H_ACTIVE    (S_HA),
    .H_FP        (S_HF),
    .H_SYNC      (S_HS),
    .H_BP        (S_HB),
    .V_ACTIVE    (S_VA),
    .V_FP        (S_VF),
    .V_SYNC      (S_VS),
    .V_BP        (S_VB),
    .SYNC_ACTIVE (S_SYNC)
  ) dutSmall (
    .clk_in1     (clk),
    .reset_n     (resetN),
    .locked      (lockedIn),
    .hsync       (sHsync),
    .vsync       (sVsync),
    .de          (sDe),
    .pixel_x     (sX),
    .pixel_y     (sY),
    .frame_start (sFs),
    .line_start  (sLs),
    .running     (sRun)
  );

  // Lock history: every clock edge records what the lock input looked like.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < 4; i++) begin
        lockHist[i] = 1'b0;
        runHist[i]  = 0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        lockHist[i] = lockHist[i-1];
        runHist[i]  = runHist[i-1];
      end
      lockHist[0] = lockedIn;
      runHist[0]  = lockedIn ? runHist[1] + 1 : 0;
    end
  end

  task automatic cmp(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
    end
  endtask

  // Outputs are due three edges after the lock sample they depend on; the
  // position in the raster is simply the number of locked cycles so far.
  task automatic checkOutput(input string tag,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input logic syncAct,
                             input logic aHs, input logic aVs, input logic aDe,
                             input logic [COORD_W-1:0] aX, input logic [COORD_W-1:0] aY,
                             input logic aFs, input logic aLs, input logic aRun);
    int   htot, vtot, pos, h, v;
    logic eHs, eVs, eDe, eFs, eLs, eRun;
    htot = ha + hf + hs + hb;
    vtot = va + vf + vs + vb;
    if (lockHist[3]) begin
      pos  = runHist[3] - 1;
      h    = pos % htot;
      v    = (pos / htot) % vtot;
      eRun = 1'b1;
      eDe  = (h < ha) && (v < va);
      eHs  = (h >= ha + hf && h < ha + hf + hs) ? syncAct : ~syncAct;
      eVs  = (v >= va + vf && v < va + vf + vs) ? syncAct : ~syncAct;
      eLs  = (h == 0);
      eFs  = (h == 0) && (v == 0);
    end else begin
      h    = 0;
      v    = 0;
      eRun = 1'b0;
      eDe  = 1'b0;
      eHs  = ~syncAct;
      eVs  = ~syncAct;
      eLs  = 1'b0;
      eFs  = 1'b0;
    end
    cmp({tag, ".running"},     aRun, eRun);
    cmp({tag, ".de"},          aDe,  eDe);
    cmp({tag, ".hsync"},       aHs,  eHs);
    cmp({tag, ".vsync"},       aVs,  eVs);
    cmp({tag, ".pixel_x"},     aX,   h);
    cmp({tag, ".pixel_y"},     aY,   v);
    cmp({tag, ".line_start"},  aLs,  eLs);
    cmp({tag, ".frame_start"}, aFs,  eFs);
  endtask

  task automatic checkBoth();
    checkOutput("full", DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
                DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_SYNC_ACTIVE,
                fHsync, fVsync, fDe, fX, fY, fFs, fLs, fRun);
    checkOutput("small", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_SYNC,
                sHsync, sVsync, sDe, sX, sY, sFs, sLs, sRun);
  endtask

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkBoth();
    end
  end

  // Hold the lock input at a level for a number of cycles; returns just
  // after a falling clock edge.
  task automatic applyStimulus(input logic lockVal, input int cycles);
    lockedIn = lockVal;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  // Count rising edges from now until the full-size raster reports frame_start.
  task automatic measureLockup(output int edges);
    edges = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (fFs) begin
        edges = i;
        break;
      end
    end
  endtask

  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges, found, deHigh, hsLow, hsFirst, lsCount, lastX, lastY;
    int vsAct, fsCount, deBad, deCnt, vsBadY, vsFirstX, frameWraps, lineWraps;
    int prevX, prevY, hold;

    // Reset, then stay unlocked for 100 cycles.
    #1 resetN = 1'b0;
    checkEn = 1'b1;
    #1 checkBoth();
    repeat (3) @(negedge clk);
    #1 resetN = 1'b1;
    applyStimulus(1'b0, 100);
    cmp("idle.full.running", fRun, 0);
    cmp("idle.full.hsync", fHsync, 1);
    cmp("idle.full.vsync", fVsync, 1);
    cmp("idle.small.hsync", sHsync, 0);
    cmp("idle.full.pixel_x", fX, 0);

    // Lock-up: first frame_start four edges after locked is first sampled.
    $display("[TB] lock-up");
    lockedIn = 1'b1;
    measureLockup(edges);
    cmp("lockup.edges", edges, 4);
    cmp("lockup.pixel_x", fX, 0);
    cmp("lockup.pixel_y", fY, 0);
    cmp("lockup.de", fDe, 1);
    cmp("lockup.line_start", fLs, 1);
    cmp("lockup.running", fRun, 1);

    // One full 640x480 line.
    $display("[TB] horizontal line");
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (fLs) found = 1;
    end
    cmp("horiz.find_line", found, 1);
    deHigh = 0; hsLow = 0; hsFirst = -1; lsCount = 0; lastX = 0; lastY = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) @(negedge clk);
      if (fDe) deHigh++;
      if (!fHsync) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = fX;
      end
      if (fLs) lsCount++;
      if (i == 799) begin
        lastX = fX;
        lastY = fY;
      end
    end
    @(negedge clk);
    cmp("horiz.de_high", deHigh, 640);
    cmp("horiz.hsync_low", hsLow, 96);
    cmp("horiz.hsync_first_x", hsFirst, 656);
    cmp("horiz.line_starts", lsCount, 1);
    cmp("horiz.next_line_start", fLs, 1);
    cmp("wrap.full.x799", lastX, 799);
    cmp("wrap.full.x0", fX, 0);
    cmp("wrap.full.y_inc", fY, lastY + 1);

    // Two full frames of the small raster.
    $display("[TB] vertical frames");
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (sFs) found = 1;
    end
    cmp("vert.find_frame", found, 1);
    vsAct = 0; fsCount = 0; deBad = 0; deCnt = 0; vsBadY = 0; vsFirstX = -1;
    frameWraps = 0; lineWraps = 0; prevX = 0; prevY = 0;
    for (int i = 0; i < 1190; i++) begin
      if (i > 0) @(negedge clk);
      if (sVsync == S_SYNC) begin
        vsAct++;
        if (vsFirstX < 0) vsFirstX = sX;
        if (sY < 11 || sY > 12) vsBadY++;
      end
      if (sFs) fsCount++;
      if (sDe) begin
        deCnt++;
        if (sY >= 8) deBad++;
      end
      if (i > 0 && prevX == 34 && prevY == 16) begin
        frameWraps++;
        cmp("wrap.frame.x", sX, 0);
        cmp("wrap.frame.y", sY, 0);
        cmp("wrap.frame.frame_start", sFs, 1);
      end
      if (i > 0 && prevX == 34 && prevY == 3) begin
        lineWraps++;
        cmp("wrap.line.x", sX, 0);
        cmp("wrap.line.y", sY, 4);
      end
      prevX = sX;
      prevY = sY;
    end
    @(negedge clk);
    cmp("vert.frame_period", sFs, 1);
    cmp("vert.vsync_cycles", vsAct, 140);
    cmp("vert.vsync_first_x", vsFirstX, 0);
    cmp("vert.vsync_bad_y", vsBadY, 0);
    cmp("vert.frame_starts", fsCount, 2);
    cmp("vert.de_cycles", deCnt, 320);
    cmp("vert.de_blank_rows", deBad, 0);
    cmp("vert.frame_wraps", frameWraps, 1);
    cmp("vert.line_wraps", lineWraps, 2);

    // Lock loss mid-line on the full raster.
    $display("[TB] lock loss");
    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      @(negedge clk);
      if (fX == 300) found = 1;
    end
    cmp("loss.find_x300", found, 1);
    #1 lockedIn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("loss.f2.running", fRun, 1);
    cmp("loss.f2.pixel_x", fX, 303);
    @(posedge clk);
    @(negedge clk);
    cmp("loss.f3.running", fRun, 0);
    cmp("loss.f3.pixel_x", fX, 0);
    cmp("loss.f3.pixel_y", fY, 0);
    cmp("loss.f3.de", fDe, 0);
    cmp("loss.f3.hsync", fHsync, 1);
    cmp("loss.f3.vsync", fVsync, 1);
    cmp("loss.f3.small_running", sRun, 0);
    cmp("loss.f3.small_hsync", sHsync, 0);

    // Relock restarts at (0,0).
    #1 applyStimulus(1'b0, 20);
    lockedIn = 1'b1;
    measureLockup(edges);
    cmp("relock.edges", edges, 4);
    cmp("relock.pixel_x", fX, 0);
    cmp("relock.pixel_y", fY, 0);

    // Asynchronous reset between edges, mid-frame.
    $display("[TB] async reset");
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (sY == 5) found = 1;
    end
    cmp("areset.find_y5", found, 1);
    cmp("areset.pre_running", fRun, 1);
    @(posedge clk);
    #2 resetN = 1'b0;
    #1;
    cmp("areset.running", fRun, 0);
    cmp("areset.de", fDe, 0);
    cmp("areset.pixel_x", fX, 0);
    cmp("areset.small_pixel_y", sY, 0);
    cmp("areset.hsync", fHsync, 1);
    cmp("areset.line_start", fLs, 0);
    checkBoth();
    @(negedge clk);
    #1 resetN = 1'b1;
    measureLockup(edges);
    cmp("areset.relock_edges", edges, 4);

    // Randomized lock drops and resets.
    $display("[TB] random phase");
    #1;
    for (int seg = 0; seg < 20; seg++) begin
      applyStimulus(1'b1, int'($urandom_range(1, 1200)));
      if ($urandom_range(0, 4) == 0) begin
        resetN = 1'b0;
        hold = int'($urandom_range(0, 3));
        if (hold == 0) begin
          #2;
        end else begin
          repeat (hold) @(negedge clk);
          #1;
        end
        resetN = 1'b1;
      end else begin
        applyStimulus(1'b0, int'($urandom_range(1, 30)));
      end
    end
    applyStimulus(1'b1, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
